// File: rtl/text_sprite_fetch_sched_pkg.sv
// Shared types and defaults for the text-sprite scanline fetch scheduler.
// Holds the sequencer state encoding and the font-range helper.
package text_sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MSG_ISSUE  = 3'd1,
    ST_MSG_DRAIN  = 3'd2,
    ST_FONT_ISSUE = 3'd3,
    ST_FONT_DRAIN = 3'd4
  } state_e;

  localparam int SPR_CNT_DEF  = 32'd8;
  localparam int MSGS_DEF     = 32'd32;
  localparam int MSG_LEN_DEF  = 32'd16;
  localparam int FONT_H_DEF   = 32'd8;
  localparam int GLYPHS_DEF   = 32'd64;
  localparam int CP_START_DEF = 32'h20;
  localparam int CP_W_DEF     = 32'd7;
  localparam int PAUSE_DEF    = 32'd80;
  localparam int ROM_LAT_DEF  = 32'd1;

  localparam int GREET_AW_DEF = $clog2(MSGS_DEF * MSG_LEN_DEF);
  localparam int FONT_AW_DEF  = $clog2(GLYPHS_DEF * FONT_H_DEF);

  // A code point maps to a glyph only inside [first, first+count).
  function automatic logic cp_in_font(input int cp, input int first, input int count);
    return (cp >= first) && (cp < first + count);
  endfunction

endpackage

// File: rtl/text_sprite_fetch_sched_if.sv
// ROM/DMA bus between the fetch scheduler, the two ROMs and the sprite array.
interface text_sprite_fetch_sched_if
  import text_sprite_pkg::*;
#(
  parameter int SPR_CNT = SPR_CNT_DEF,
  parameter int MSGS    = MSGS_DEF,
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int FONT_H  = FONT_H_DEF,
  parameter int GLYPHS  = GLYPHS_DEF,
  parameter int CP_W    = CP_W_DEF
);
  localparam int GA_W = $clog2(MSGS * MSG_LEN);
  localparam int FA_W = $clog2(GLYPHS * FONT_H);

  logic [GA_W-1:0]    greet_rom_addr;
  logic [CP_W-1:0]    greet_rom_data;
  logic [FA_W-1:0]    font_rom_addr;
  logic [SPR_CNT-1:0] dma_avail;

  modport master (
    output greet_rom_addr,
    output font_rom_addr,
    output dma_avail,
    input  greet_rom_data
  );

  modport slave (
    input  greet_rom_addr,
    input  font_rom_addr,
    input  dma_avail,
    output greet_rom_data
  );
endinterface

// File: rtl/text_sprite_fetch_sched_greeting_sel.sv
// Greeting selector: counts frame pulses and steps to the next message
// every PAUSE frames, wrapping after the last message.
module greeting_sel
  import text_sprite_pkg::*;
#(
  parameter int MSGS  = MSGS_DEF,
  parameter int PAUSE = PAUSE_DEF
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    frame,
  output logic [$clog2(MSGS)-1:0] greeting
);
  localparam int GW = $clog2(MSGS);
  localparam int FW = (PAUSE > 1) ? $clog2(PAUSE) : 1;
  localparam logic [FW-1:0] FRM_LAST   = FW'(PAUSE - 1);
  localparam logic [GW-1:0] GREET_LAST = GW'(MSGS - 1);

  logic [FW-1:0] frm_cnt_r;
  logic [GW-1:0] greeting_r;

  // Frame counter and message index advance.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      frm_cnt_r  <= '0;
      greeting_r <= '0;
    end else if (frame) begin
      if (frm_cnt_r == FRM_LAST) begin
        frm_cnt_r  <= '0;
        greeting_r <= (greeting_r == GREET_LAST) ? '0 : greeting_r + GW'(1'b1);
      end else begin
        frm_cnt_r <= frm_cnt_r + FW'(1'b1);
      end
    end
  end

  assign greeting = greeting_r;

endmodule

// File: rtl/text_sprite_fetch_sched.sv
// Per-scanline DMA scheduler: fetches one row of code points from the greeting
// ROM, then one glyph line per sprite slot from the font ROM.
module text_sprite_fetch_sched
  import text_sprite_pkg::*;
#(
  parameter int SPR_CNT  = SPR_CNT_DEF,
  parameter int MSGS     = MSGS_DEF,
  parameter int MSG_LEN  = MSG_LEN_DEF,
  parameter int FONT_H   = FONT_H_DEF,
  parameter int GLYPHS   = GLYPHS_DEF,
  parameter int CP_START = CP_START_DEF,
  parameter int CP_W     = CP_W_DEF,
  parameter int PAUSE    = PAUSE_DEF,
  parameter int ROM_LAT  = ROM_LAT_DEF
) (
  input  logic                               clk_pix,
  input  logic                               rst_pix_n,
  input  logic                               frame,
  input  logic                               start,
  input  logic                               row,
  input  logic [SPR_CNT*$clog2(FONT_H)-1:0]  glyph_line,
  text_sprite_fetch_sched_if.master          bus,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(MSGS)-1:0]            greeting,
  output logic                               overrun,
  output logic                               bad_cp
);
  localparam int LW   = $clog2(FONT_H);
  localparam int GA_W = $clog2(MSGS * MSG_LEN);
  localparam int FA_W = $clog2(GLYPHS * FONT_H);
  localparam int GI_W = $clog2(GLYPHS);
  localparam int GW   = $clog2(MSGS);
  localparam int IW   = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;

  // Cycle numbers relative to the accept edge (cycle 1 follows it).
  localparam int FIRST_CYC  = 32'd1;
  localparam int MSG_END    = SPR_CNT;
  localparam int CAP_FIRST  = 32'd1 + ROM_LAT;
  localparam int CAP_END    = SPR_CNT + ROM_LAT;
  localparam int FONT_FIRST = SPR_CNT + ROM_LAT + 32'd1;
  localparam int FONT_END   = 2 * SPR_CNT + ROM_LAT;
  localparam int DMA_FIRST  = SPR_CNT + 2 * ROM_LAT + 32'd1;
  localparam int BUSY_END   = 2 * SPR_CNT + 2 * ROM_LAT;
  localparam int LAST_CYC   = BUSY_END + 32'd1;
  localparam int CW         = $clog2(LAST_CYC + 1);

  localparam logic [SPR_CNT-1:0] SLOT0 = SPR_CNT'(1'b1);

  state_e                   state_r;
  logic [CW-1:0]            cyc_r;
  logic [CW-1:0]            cyc_nxt_s;
  logic                     accept_s;
  int                       n_i;
  int                       c_i;

  logic [GA_W-1:0]          base_r;
  logic [GA_W-1:0]          base_live_s;
  logic [GA_W-1:0]          gbase_s;
  logic [GA_W-1:0]          gaddr_s;
  logic [SPR_CNT*LW-1:0]    gl_r;
  logic [CP_W-1:0]          cp_r [SPR_CNT];

  logic                     gissue_s;
  logic                     fissue_s;
  logic                     dma_s;
  logic                     cap_s;
  logic [IW-1:0]            gj_s;
  logic [IW-1:0]            fj_s;
  logic [IW-1:0]            dj_s;
  logic [IW-1:0]            cj_s;
  logic [CP_W-1:0]          fcp_s;
  logic                     fin_s;
  logic [GI_W-1:0]          fgidx_s;
  logic [FA_W-1:0]          faddr_s;

  logic [GA_W-1:0]          greet_addr_r;
  logic [FA_W-1:0]          font_addr_r;
  logic [SPR_CNT-1:0]       dma_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     overrun_r;
  logic                     bad_cp_r;
  logic [GW-1:0]            greeting_s;

  greeting_sel #(
    .MSGS  (MSGS),
    .PAUSE (PAUSE)
  ) u_greeting_sel (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .frame     (frame),
    .greeting  (greeting_s)
  );

  // Cycle number the sequencer will be in after the coming edge (0 = idle).
  always_comb begin
    accept_s  = 1'b0;
    cyc_nxt_s = '0;
    if (state_r == ST_IDLE) begin
      accept_s = start;
      if (start) begin
        cyc_nxt_s = CW'(1'b1);
      end else begin
        cyc_nxt_s = '0;
      end
    end else begin
      cyc_nxt_s = cyc_r + CW'(1'b1);
    end
  end

  assign n_i = int'(cyc_nxt_s);
  assign c_i = int'(cyc_r);

  // Decode of the next cycle's issue slots and this cycle's capture slot.
  always_comb begin
    gissue_s = (n_i >= FIRST_CYC) && (n_i <= MSG_END);
    fissue_s = (n_i >= FONT_FIRST) && (n_i <= FONT_END);
    dma_s    = (n_i >= DMA_FIRST) && (n_i <= BUSY_END);
    cap_s    = (state_r != ST_IDLE) && (c_i >= CAP_FIRST) && (c_i <= CAP_END);
    gj_s     = IW'(n_i - FIRST_CYC);
    fj_s     = IW'(n_i - FONT_FIRST);
    dj_s     = IW'(n_i - DMA_FIRST);
    cj_s     = IW'(c_i - CAP_FIRST);

    // The first address is issued on the accept edge, before base_r is loaded.
    base_live_s = GA_W'(greeting_s) * GA_W'(MSG_LEN) + (row ? GA_W'(SPR_CNT) : '0);
    gbase_s     = (state_r == ST_IDLE) ? base_live_s : base_r;
    gaddr_s     = gbase_s + GA_W'(gj_s);

    fcp_s   = cp_r[fj_s];
    fin_s   = cp_in_font(int'(fcp_s), CP_START, GLYPHS);
    fgidx_s = fin_s ? GI_W'(int'(fcp_s) - CP_START) : '0;
    faddr_s = FA_W'(fgidx_s) * FA_W'(FONT_H) + FA_W'(gl_r[fj_s*LW +: LW]);
  end

  // Sequencer FSM, per-sequence snapshots and all registered outputs.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_r      <= ST_IDLE;
      cyc_r        <= '0;
      base_r       <= '0;
      gl_r         <= '0;
      for (int i = 0; i < SPR_CNT; i++) begin
        cp_r[i] <= '0;
      end
      greet_addr_r <= '0;
      font_addr_r  <= '0;
      dma_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
      bad_cp_r     <= 1'b0;
    end else begin
      cyc_r        <= cyc_nxt_s;
      greet_addr_r <= gissue_s ? gaddr_s : '0;
      font_addr_r  <= fissue_s ? faddr_s : '0;
      dma_r        <= dma_s ? (SLOT0 << dj_s) : '0;
      busy_r       <= (n_i >= FIRST_CYC) && (n_i <= BUSY_END);
      done_r       <= (n_i == LAST_CYC);

      if (cap_s) begin
        cp_r[cj_s] <= bus.greet_rom_data;
      end
      if (start && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      if (fissue_s && !fin_s) begin
        bad_cp_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_MSG_ISSUE;
            base_r  <= base_live_s;
            gl_r    <= glyph_line;
          end
        end
        ST_MSG_ISSUE: begin
          if (n_i == MSG_END + 1) begin
            state_r <= ST_MSG_DRAIN;
          end
        end
        ST_MSG_DRAIN: begin
          if (n_i == FONT_FIRST) begin
            state_r <= ST_FONT_ISSUE;
          end
        end
        ST_FONT_ISSUE: begin
          if (n_i == FONT_END + 1) begin
            state_r <= ST_FONT_DRAIN;
          end
        end
        ST_FONT_DRAIN: begin
          if (n_i == LAST_CYC) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.greet_rom_addr = greet_addr_r;
  assign bus.font_rom_addr  = font_addr_r;
  assign bus.dma_avail      = dma_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign greeting           = greeting_s;
  assign overrun            = overrun_r;
  assign bad_cp             = bad_cp_r;

endmodule

// File: tb/tb_text_sprite_fetch_sched.sv
// Directed bench for text_sprite_fetch_sched with a one-cycle greeting ROM model.
module tb_text_sprite_fetch_sched;
  import text_sprite_pkg::*;

  localparam int PAUSE_TB = 4;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n;
  logic        frame;
  logic        start;
  logic        row;
  logic [23:0] glyph_line;
  logic        busy;
  logic        done;
  logic [4:0]  greeting;
  logic        overrun;
  logic        bad_cp;

  int n_vec = 0;
  int n_err = 0;
  int exp_fa [8];
  logic [6:0] gmem [512];

  text_sprite_fetch_sched_if bus ();

  text_sprite_fetch_sched #(.PAUSE(PAUSE_TB)) dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .frame      (frame),
    .start      (start),
    .row        (row),
    .glyph_line (glyph_line),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .greeting   (greeting),
    .overrun    (overrun),
    .bad_cp     (bad_cp)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) bus.greet_rom_data <= gmem[bus.greet_rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    step();
    frame = 1'b0;
    step();
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered in cycle 1 of a sequence; leaves in its cycle 19.
  task automatic check_seq(input string pfx, input int gbase, input int s1, input int s2);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) step();
      start = 1'b0;
      chk($sformatf("%s c%0d greet_addr", pfx, c), 32'(bus.greet_rom_addr),
          (c <= 8) ? 32'(gbase + c - 1) : 32'd0);
      chk($sformatf("%s c%0d font_addr", pfx, c), 32'(bus.font_rom_addr),
          (c >= 10 && c <= 17) ? 32'(exp_fa[c-10]) : 32'd0);
      chk($sformatf("%s c%0d dma_avail", pfx, c), 32'(bus.dma_avail),
          (c >= 11 && c <= 18) ? (32'd1 << (c - 11)) : 32'd0);
      chk($sformatf("%s c%0d busy", pfx, c), 32'(busy), 32'(c <= 18));
      chk($sformatf("%s c%0d done", pfx, c), 32'(done), 32'(c == 19));
      if (c == s1 || c == s2) start = 1'b1;
    end
  endtask

  task automatic load_test1();
    for (int j = 0; j < 8; j++) begin
      gmem[j] = 7'(32'h41 + j);
      glyph_line[j*3 +: 3] = 3'(7 - j);
      exp_fa[j] = (32'h21 + j) * 8 + (7 - j);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) gmem[i] = 7'h00;
    rst_pix_n  = 1'b0;
    frame      = 1'b0;
    start      = 1'b0;
    row        = 1'b0;
    glyph_line = 24'h0;
    step();
    step();
    chk("rst greet_addr", 32'(bus.greet_rom_addr), 32'd0);
    chk("rst font_addr", 32'(bus.font_rom_addr), 32'd0);
    chk("rst dma_avail", 32'(bus.dma_avail), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst greeting", 32'(greeting), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst bad_cp", 32'(bad_cp), 32'd0);
    rst_pix_n = 1'b1;
    step();

    // Greeting 0, row 0; glyph_line changes after accept must not leak in.
    load_test1();
    launch();
    glyph_line = 24'hFFFFFF;
    check_seq("t1", 0, 0, 0);
    chk("t1 bad_cp", 32'(bad_cp), 32'd0);
    chk("t1 overrun", 32'(overrun), 32'd0);

    // Frame pacing with PAUSE=4.
    for (int p = 1; p <= 9; p++) begin
      pulse_frame();
      if (p == 3) chk("frm3 greeting", 32'(greeting), 32'd0);
      if (p == 4) chk("frm4 greeting", 32'(greeting), 32'd1);
      if (p == 7) chk("frm7 greeting", 32'(greeting), 32'd1);
      if (p == 8) chk("frm8 greeting", 32'(greeting), 32'd2);
      if (p == 9) chk("frm9 greeting", 32'(greeting), 32'd2);
    end
    for (int p = 0; p < 6; p++) pulse_frame();
    chk("pre t2 greeting", 32'(greeting), 32'd3);

    // Row 1 of greeting 3, frame on the accept edge moves greeting to 4.
    for (int j = 0; j < 8; j++) begin
      gmem[56 + j] = 7'(32'h30 + j);
      glyph_line[j*3 +: 3] = (j == 5) ? 3'd6 : 3'(j);
      exp_fa[j] = (32'h10 + j) * 8 + ((j == 5) ? 6 : j);
    end
    row   = 1'b1;
    frame = 1'b1;
    launch();
    frame = 1'b0;
    row   = 1'b0;
    glyph_line = 24'h0;
    chk("t2 greeting c1", 32'(greeting), 32'd4);
    check_seq("t2", 56, 0, 0);
    chk("t2 slot5 font_addr", 32'(exp_fa[5]), 32'd174);

    // Out-of-font code points and the font-range boundaries, greeting 4 row 0.
    gmem[64] = 7'h20; gmem[65] = 7'h21; gmem[66] = 7'h10; gmem[67] = 7'h7F;
    gmem[68] = 7'h5F; gmem[69] = 7'h60; gmem[70] = 7'h26; gmem[71] = 7'h27;
    exp_fa[0] = 0;   exp_fa[1] = 9; exp_fa[2] = 2;  exp_fa[3] = 3;
    exp_fa[4] = 508; exp_fa[5] = 5; exp_fa[6] = 54; exp_fa[7] = 63;
    for (int j = 0; j < 8; j++) glyph_line[j*3 +: 3] = 3'(j);
    chk("t3 bad_cp before", 32'(bad_cp), 32'd0);
    launch();
    check_seq("t3", 64, 0, 0);
    chk("t3 bad_cp after", 32'(bad_cp), 32'd1);

    // Start during the sequence is ignored; start with done chains a second one.
    chk("t4 overrun before", 32'(overrun), 32'd0);
    launch();
    check_seq("t4a", 64, 5, 19);
    step();
    start = 1'b0;
    check_seq("t4b", 64, 0, 0);
    chk("t4 overrun", 32'(overrun), 32'd1);
    chk("t4 bad_cp sticky", 32'(bad_cp), 32'd1);
    chk("t4 greeting", 32'(greeting), 32'd4);

    // Reset in cycle 12 of a sequence.
    launch();
    for (int c = 2; c <= 12; c++) step();
    chk("t5 c12 dma pre", 32'(bus.dma_avail), 32'h2);
    rst_pix_n = 1'b0;
    #1;
    chk("t5 rst dma_avail", 32'(bus.dma_avail), 32'd0);
    chk("t5 rst busy", 32'(busy), 32'd0);
    chk("t5 rst done", 32'(done), 32'd0);
    chk("t5 rst greeting", 32'(greeting), 32'd0);
    chk("t5 rst overrun", 32'(overrun), 32'd0);
    chk("t5 rst bad_cp", 32'(bad_cp), 32'd0);
    step();
    step();
    rst_pix_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5 post dma_avail", 32'(bus.dma_avail), 32'd0);
      chk("t5 post busy", 32'(busy), 32'd0);
      chk("t5 post done", 32'(done), 32'd0);
    end
    load_test1();
    launch();
    check_seq("t6", 0, 0, 0);
    chk("t6 bad_cp", 32'(bad_cp), 32'd0);
    chk("t6 overrun", 32'(overrun), 32'd0);

    // Walk to the last greeting and wrap.
    for (int p = 0; p < 124; p++) pulse_frame();
    chk("wrap greeting 31", 32'(greeting), 32'd31);
    for (int p = 0; p < 3; p++) pulse_frame();
    chk("wrap hold 31", 32'(greeting), 32'd31);
    pulse_frame();
    chk("wrap to 0", 32'(greeting), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_sprite_fetch_sched.md
Name: text_sprite_fetch_sched

Overview:
- Per-scanline DMA scheduler for the 8x8 text-sprite pipeline. On each start pulse, issued during h-blanking, it performs two phases:
  - reads one row of code points from the greeting ROM;
  - reads one glyph line per sprite from the font ROM, pulsing each sprite's dma_avail when its data is valid.
- It also owns greeting selection: every PAUSE frames it advances to the next message, wrapping around.
- Sits between the video timing generator, the two rom_sync instances and the sprite array.

Parameters:
- SPR_CNT, 8, sprites per text row (slots).
- MSGS, 32, number of greeting messages.
- MSG_LEN, 16, code points per message (= 2*SPR_CNT, two rows).
- FONT_H, 8, glyph height in lines.
- GLYPHS, 64, glyphs in the font ROM.
- CP_START, 'h20, first code point in the font ROM.
- CP_W, 7, code-point width.
- PAUSE, 80, frames per greeting.
- ROM_LAT, 1, read latency of both ROMs (cycles).

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix_n  in  1  asynchronous, active-low reset.
- frame  in  1  frame-start pulse.
- start  in  1  one-cycle request to begin a scanline fetch.
- row  in  1  text row, 0 or 1; selects message half.
- glyph_line  in  SPR_CNT*$clog2(FONT_H)  per-slot glyph line; slot j occupies bits [j*3+:3].
- greet_rom_addr  out  $clog2(MSGS*MSG_LEN)  greeting ROM address.
- greet_rom_data  in  CP_W  greeting ROM data.
- font_rom_addr  out  $clog2(GLYPHS*FONT_H)  font ROM address.
- dma_avail  out  SPR_CNT  one-hot, one-cycle "font_rom_data valid for slot j".
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- greeting  out  $clog2(MSGS)  current message index.
- overrun  out  1  sticky: start arrived while busy.
- bad_cp  out  1  sticky: code point outside the font.

Behaviour:
- Reset (async assert, sync deassert handled upstream) zeroes every output, the frame counter, greeting, the code-point registers and the FSM (IDLE).
- Greeting selector:
  - On frame, frm_cnt increments.
  - When frm_cnt == PAUSE-1 and frame is high: frm_cnt <= 0 and greeting <= greeting+1, wrapping MSGS-1 -> 0.
  - Period is exactly PAUSE frames.
- Snapshot on an accepted start (IDLE, start=1):
  - base = greeting*MSG_LEN + row*SPR_CNT;
  - all glyph_line slots.
  - A greeting change mid-sequence does not affect the current sequence.
- FSM states: IDLE -> MSG_ISSUE -> MSG_DRAIN -> FONT_ISSUE -> FONT_DRAIN -> IDLE. All outputs are registered.
- Timing is counted in cycles after the accept edge (cycle 1 = first cycle after it).
- MSG_ISSUE, cycles 1..SPR_CNT:
  - greet_rom_addr = base+j in cycle j+1.
  - cp[j] is captured from greet_rom_data in cycle j+1+ROM_LAT.
- MSG_DRAIN lasts ROM_LAT cycles.
- FONT_ISSUE, cycles N+ROM_LAT+1+j (N = SPR_CNT):
  - font_rom_addr = gidx[j]*FONT_H + glyph_line[j].
  - gidx = cp-CP_START when CP_START <= cp < CP_START+GLYPHS.
  - Otherwise gidx = 0 (blank) and bad_cp is set.
- dma_avail[j] is high only in cycle N+2*ROM_LAT+1+j.
- FONT_DRAIN lasts ROM_LAT cycles.
- done pulses in cycle 2N+2*ROM_LAT+1. busy is high for cycles 1..2N+2*ROM_LAT and low when done is high.
  - N=8, ROM_LAT=1: done in cycle 19.
- Address outputs hold 0 when not issuing.
- start while busy: ignored, overrun <= 1, the sequence continues unchanged.
- start in the same cycle as done: accepted, so back-to-back sequences are allowed.
- frame coincident with start: the greeting update and the snapshot happen on the same edge; the snapshot uses the pre-update greeting.
- Reset mid-sequence: all dma_avail, busy and done drop immediately, with no partial pulses after release.
- Address arithmetic is unsigned, computed at full address width, no truncation warnings: greeting*MSG_LEN + row*SPR_CNT + j ≤ MSGS*MSG_LEN-1 by construction.

Decomposition:
- Package text_sprite_pkg:
  - state enum;
  - CP_START, FONT_H, GLYPHS, MSG_LEN defaults;
  - derived address widths.
- Sub-module greeting_sel: frame counter plus greeting wrap, with ports clk_pix, rst_pix_n, frame, greeting.

Test Plan:
- Reset, then start with greeting=0, row=0, ROM loaded with cp 'h41+j:
  - greet_rom_addr 0..7 in cycles 1..8;
  - font_rom_addr ('h21+j)*8 + glyph_line[j] in cycles 10..17;
  - dma_avail[j] in cycle 11+j;
  - done in cycle 19.
- row=1, greeting=3: greet_rom_addr 56..63; glyph_line[5]=6 -> slot 5 font_rom_addr = gidx*8+6.
- PAUSE=4, 9 frame pulses: greeting steps 0->1 at the 4th pulse, ->2 at the 8th. With greeting=31, the next advance wraps to 0.
- cp 'h10 and 'h7F in slots 2 and 3: font_rom_addr = glyph_line (gidx 0) for both; bad_cp=1, sticky until reset.
- start again in cycle 5 of a sequence: ignored and overrun=1, done still in cycle 19. start in cycle 19 is accepted, and the next done arrives in cycle 38.
- rst_pix_n low in cycle 12: dma_avail=0, busy=0 and greeting=0 immediately. After release, start produces a clean full sequence.
